// File: rtl/acc_ff.sv
// Registered unsigned accumulator: sums LEN products and hands out each sum
// over a valid/ready handshake, with a sticky carry-out flag per sum.
module acc_ff #(
  parameter int unsigned BWOP = 32,
  parameter int unsigned ACCW = 40,
  parameter int unsigned LEN  = 8,
  localparam int unsigned CW  = $clog2(LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [BWOP-1:0] in_c,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_sum,
  output logic            out_ovf,
  output logic [CW-1:0]   beat_cnt
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [ACCW-1:0]   acc, acc_n;
  logic              ovf, ovf_n;
  logic [CW-1:0]     cnt_n;
  logic [ACCW-1:0]   sum_n;
  logic              sum_ovf_n;
  logic [ACCW:0]     add;

  // State and all outputs are registered; in_ready/out_valid track the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACC;
      acc       <= '0;
      ovf       <= 1'b0;
      beat_cnt  <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      ovf       <= ovf_n;
      beat_cnt  <= cnt_n;
      out_sum   <= sum_n;
      out_ovf   <= sum_ovf_n;
      in_ready  <= (state_n == ACC);
      out_valid <= (state_n == HOLD);
    end
  end

  // Next-state and datapath; the extra top bit of add is the carry out.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    ovf_n     = ovf;
    cnt_n     = beat_cnt;
    sum_n     = out_sum;
    sum_ovf_n = out_ovf;
    add       = {1'b0, acc} + (ACCW + 1)'(in_c);

    if (clr) begin
      state_n   = ACC;
      acc_n     = '0;
      ovf_n     = 1'b0;
      cnt_n     = '0;
      sum_n     = '0;
      sum_ovf_n = 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (beat_cnt == CW'(LEN - 1)) begin
              sum_n     = add[ACCW-1:0];
              sum_ovf_n = ovf | add[ACCW];
              acc_n     = '0;
              ovf_n     = 1'b0;
              cnt_n     = '0;
              state_n   = HOLD;
            end else begin
              acc_n = add[ACCW-1:0];
              ovf_n = ovf | add[ACCW];
              cnt_n = beat_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_n = ACC;
        end
        default: state_n = ACC;
      endcase
    end
  end

endmodule

// File: doc/acc_ff.md
# acc_ff

Registered unsigned accumulator that sits directly downstream of the approximate multiplier register stage. It sums LEN consecutive products into a wide accumulator and presents each completed sum with a valid/ready handshake. A sticky overflow flag marks any sum whose true value exceeded ACCW bits. The block is used to measure accumulated approximation error of dot products built from NAB-approximate multipliers.

## Interface
- BWOP, 32, product width; must match the multiplier operand width.
- ACCW, 40, accumulator and result width; must be ≥ BWOP.
- LEN, 8, products per sum; must be ≥ 1. Counter width is clog2(LEN+1).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush; highest priority after rst.
- in_valid  in  1  in_c holds a valid product this cycle. The feeder delays operand valid by one cycle to align with the multiplier register.
- in_c  in  BWOP  product, unsigned.
- in_ready  out  1  block accepts in_c this cycle.
- out_valid  out  1  out_sum holds a completed sum.
- out_ready  in  1  consumer accepts out_sum.
- out_sum  out  ACCW  completed sum of LEN products, modulo 2^ACCW.
- out_ovf  out  1  carry out of bit ACCW-1 occurred during this sum.
- beat_cnt  out  clog2(LEN+1)  products accepted into the current sum.

## Operation
- Two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept occurs when in_valid & in_ready.
- Each accept in ACC:
  - acc ← acc + zero_ext(in_c).
  - ovf ← ovf | carry out of the addition.
  - beat_cnt increments.
- On the accept that makes beat_cnt reach LEN:
  - out_sum ← acc + in_c.
  - out_ovf ← ovf | carry.
  - acc, ovf and beat_cnt are cleared.
  - State moves to HOLD.
- in_valid in HOLD is ignored. The feeder must stall, since in_ready=0.
- HOLD with out_ready=1 returns to ACC on the next edge.
  - out_sum and out_ovf keep their values until overwritten by the next completed sum.
- HOLD with out_ready=0: out_valid, out_sum and out_ovf hold stable.
- Arithmetic:
  - Unsigned, wrap modulo 2^ACCW.
  - No saturation.
  - in_c is never sign-extended.
- clr=1 on an edge, in any state:
  - acc=0, ovf=0, beat_cnt=0, state=ACC, out_valid=0.
  - out_sum and out_ovf are cleared.
  - An in_valid beat in the same cycle is discarded.
- LEN=1: every accepted beat completes a sum. The block alternates ACC/HOLD.

## Timing
- Reset values: state=ACC, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, beat_cnt=0, internal acc=0.
- Latency: out_valid rises on the edge after the LEN-th accept. The sum is visible in that same cycle.
- Throughput:
  - Consumer with out_ready tied high: one sum per LEN+1 cycles.
  - in_ready is low for exactly one cycle per sum.
- in_ready is a registered-state decode only, with no combinational path from out_ready. out_ready affects state only at the next edge.
- Reset mid-sum discards partial accumulation immediately, asynchronously. The first accept after rst release begins a new sum.
- All outputs change only on clk edges or on rst assertion.

## Test plan
- Reset: assert rst mid-sum with beat_cnt=5 → all outputs return to reset values at once. After release, 8 beats of 1 → out_sum=8, out_ovf=0.
- Basic sum, LEN=8: in_c=1..8 on consecutive cycles, out_ready=1 → out_valid for one cycle, out_sum=36. in_ready low on that cycle, then high.
- Backpressure: out_ready=0 for 5 cycles after completion while in_valid=1 with in_c=7 → out_sum stays 36 and no beats are accepted. out_ready=1 → next sum starts from 0.
- Overflow, BWOP=32, ACCW=33: 8 beats of 0xFFFFFFFF → out_ovf=1 and out_sum = (8×0xFFFFFFFF) mod 2^33 = 0x1FFFFFFF8. The next sum of zeros gives out_ovf=0.
- clr priority: 4 beats of 10, then clr=1 together with in_valid and in_c=99 → beat_cnt=0. The next 8 beats of 2 give out_sum=16.
- Gapped input, LEN=1: in_valid on alternate cycles with in_c=3,5 → two sums, 3 then 5, each out_valid one cycle after its accept.
